rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded resource (select lines, chip enables) among 8 requesters.
- Registers a winning 3-bit index and drives the one-hot grant through an enabled 3-to-8 decoder stage.
- Grant is held while the winner keeps requesting. Rotation is fair, starting from the slot after the last winner.
- Sits between requesting masters and the decoded shared resource.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant is held while others wait. Used only when the optional feature is compiled in. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- gnt  output  8  one-hot grant; all zeros when nothing granted
- gnt_idx  output  3  binary index of current grant holder; 0 when idle
- gnt_valid  output  1  high while a grant is active; acts as the decoder enable

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. With rst high at a rising edge, the next state is:
  - gnt=8'b0, gnt_idx=3'b0, gnt_valid=0, state=IDLE
  - last-winner pointer=3'd7, so requester 0 has first priority
  - hold counter=0
- Reset mid-grant: the grant drops at that edge. No partial outputs.
- Decoded grant: gnt = gnt_valid ? (8'b1 << gnt_idx) : 8'b0.
  - Registered index through the combinational decoder; no registered one-hot.
  - gnt is never multi-hot.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, the winner is the first set bit scanning last+1, last+2, ... modulo 8, with wrap 7 -> 0.
  - At the same edge: gnt_idx=winner, gnt_valid=1, last=winner, counter=0, go to GRANT.
  - Latency: req seen at edge N gives gnt high after edge N, i.e. 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT, holder h:
  - req[h]=1 (and no forced rotation): hold the grant; counter increments, saturating at MAX_HOLD-1.
  - req[h]=0, others pending: rescan from h+1 excluding h and grant the new winner at the same edge. Back-to-back grants have no idle bubble.
  - req[h]=0, none pending: go to IDLE; gnt_valid=0, gnt_idx=0. last stays h.
- Simultaneous requests: round-robin order only. No fixed priority except at reset (pointer 7, so 0 wins).
- A requester re-raising req right after release waits behind all other pending requesters.
- Requests arriving while a grant is held are ignored until the next arbitration point.

Optional Feature:
- Macro: RR_ARBITER_TIMEOUT_EN.
- Defined: when counter == MAX_HOLD-1 while in GRANT, req[h]=1 and another req bit is set, force rotation at that edge.
  - The next winner is scanned from h+1 excluding h.
  - h re-queues normally.
  - If no other request is pending, h keeps the grant and the counter stays saturated.
- Undefined: no counter logic; the grant is held indefinitely while req[h]=1. MAX_HOLD is ignored.

Decomposition:
- Package rr_arbiter_pkg:
  - N_REQ=8, IDX_W=3
  - state encoding (IDLE=1'b0, GRANT=1'b1)
  - CNT_W=8
- Sub-module onehot_dec_3_8:
  - Ports: a[2:0], e, y[7:0].
  - Combinational, enabled 3-to-8 decoder driving gnt from gnt_idx and gnt_valid.
- Round-robin scan stays inside rr_arbiter_8 as a rotate + priority-encode function.

Test Plan:
- Reset/first grant: hold rst 2 cycles with req=8'hFF, release -> one edge later gnt=8'h01, gnt_idx=0, gnt_valid=1. During reset, gnt=0.
- Rotation with wrap: req=8'b1000_0001. Drop req[0] after 3 cycles -> gnt=8'h80 next edge, with no idle cycle. Drop req[7], re-raise req[0] -> gnt=8'h01.
- Fairness: req=8'hFF, each holder drops its req for 1 cycle after being granted -> grant order 0,1,2,...,7,0.
- Idle return: single req[5] pulse of 4 cycles -> gnt=8'h20 for 4 cycles, then gnt=0, gnt_valid=0. Next req=8'h21 -> gnt=8'h01 (scan starts at 6, wraps).
- Reset mid-grant: gnt=8'h08 active, assert rst one cycle with req unchanged -> gnt=0 at that edge. Then gnt=8'h01 if req[0] is set, else the lowest set bit.
- Timeout (RR_ARBITER_TIMEOUT_EN, MAX_HOLD=4): req[2] and req[6] held high -> gnt=8'h04 for exactly 4 cycles, then 8'h40 for 4, then 8'h04. Without the macro -> gnt=8'h04 forever.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// Enabled 3-to-8 decoder turning the registered grant index into one-hot select lines.
module onehot_dec_3_8 (
    input  logic [2:0] a,
    input  logic       e,
    output logic [7:0] y
);

    always_comb begin
        y = e ? (8'b1 << a) : 8'b0;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one decoded resource.
// Optional hold limit compiled in with `define RR_ARBITER_TIMEOUT_EN (uses MAX_HOLD).
module rr_arbiter_8
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic                  gnt_valid
);

    // state | meaning
    // IDLE  | no grant outstanding, arbitrate any request from last_q+1
    // GRANT | idx_q owns the resource until it drops req (or is forced off)

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [N_REQ-1:0]   others;
    logic [IDX_W:0]     scan_idle;
    logic [IDX_W:0]     scan_rot;
    logic               force_rot;
    logic               release_gnt;

    // Rotate so slot last+1 sits at bit 0, take the lowest set bit, undo the rotation.
    // MSB of the result flags that any bit was found.
    function automatic logic [IDX_W:0] rr_scan(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] last);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   start;
        start   = last + 1'b1;
        dbl     = {v, v} >> start;
        rot     = dbl[N_REQ-1:0];
        rr_scan = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rr_scan = {1'b1, start + IDX_W'(i)};
            end
        end
    endfunction

    assign others    = req & ~(N_REQ'(1) << idx_q);
    assign scan_idle = rr_scan(req, last_q);
    assign scan_rot  = rr_scan(others, idx_q);

`ifdef RR_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_max;

    assign hold_max  = (cnt_q == CNT_W'(MAX_HOLD - 1));
    assign force_rot = hold_max && (others != '0);
`else
    assign force_rot = 1'b0;
`endif

    assign release_gnt = !req[idx_q] || force_rot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (scan_idle[IDX_W]) begin
                    state_d = GRANT;
                    idx_d   = scan_idle[IDX_W-1:0];
                    last_d  = scan_idle[IDX_W-1:0];
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!release_gnt) begin
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d = hold_max ? cnt_q : cnt_q + 1'b1;
`endif
                end else if (scan_rot[IDX_W]) begin
                    // Hand over in the same edge so back-to-back grants have no bubble.
                    idx_d  = scan_rot[IDX_W-1:0];
                    last_d = scan_rot[IDX_W-1:0];
`ifdef RR_ARBITER_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt_valid = (state_q == GRANT);
        gnt_idx   = idx_q;
    end

    onehot_dec_3_8 u_dec (
        .a (gnt_idx),
        .e (gnt_valid),
        .y (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a per-cycle reference model and literal checkpoints.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int m_holder = -1;
    int m_last   = 7;
    int m_cnt    = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    function automatic int scan(input logic [7:0] v, input int start);
        for (int k = 1; k <= 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: who should hold the resource after each edge.
    always @(posedge clk) begin
        logic [7:0] oth;
        bit         keep;
        int         w;
        if (rst) begin
            m_holder <= -1;
            m_last   <= 7;
            m_cnt    <= 0;
        end else if (m_holder < 0) begin
            if (req != 8'h00) begin
                w = scan(req, m_last);
                m_holder <= w;
                m_last   <= w;
                m_cnt    <= 0;
            end
        end else begin
            oth  = req & ~(8'd1 << m_holder);
            keep = req[m_holder];
`ifdef RR_ARBITER_TIMEOUT_EN
            if (m_cnt == MAX_HOLD - 1 && oth != 8'h00) keep = 1'b0;
`endif
            if (keep) begin
                m_cnt <= (m_cnt < MAX_HOLD - 1) ? m_cnt + 1 : m_cnt;
            end else if (oth != 8'h00) begin
                w = scan(oth, m_holder);
                m_holder <= w;
                m_last   <= w;
                m_cnt    <= 0;
            end else begin
                m_holder <= -1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt", gnt, (m_holder < 0) ? 8'h00 : (8'd1 << m_holder));
            check("model_idx", {5'b0, gnt_idx}, (m_holder < 0) ? 8'h00 : 8'(m_holder));
            check("model_valid", {7'b0, gnt_valid}, (m_holder < 0) ? 8'h00 : 8'h01);
        end
    end

    task automatic step(input logic r, input logic [7:0] v);
        rst = r;
        req = v;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [7:0] eg, input logic [2:0] ei, input logic ev);
        check({name, "_gnt"}, gnt, eg);
        check({name, "_idx"}, {5'b0, gnt_idx}, {5'b0, ei});
        check({name, "_valid"}, {7'b0, gnt_valid}, {7'b0, ev});
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [7:0] fair_req;
        int         nxt;

        step(1'b1, 8'hFF);
        lit("reset_a", 8'h00, 3'd0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 8'hFF);
        lit("reset_b", 8'h00, 3'd0, 1'b0);
        step(1'b0, 8'hFF);
        lit("first_grant", 8'h01, 3'd0, 1'b1);

        repeat (3) begin
            step(1'b0, 8'h81);
            lit("hold_0", 8'h01, 3'd0, 1'b1);
        end
        step(1'b0, 8'h80);
        lit("wrap_to_7", 8'h80, 3'd7, 1'b1);
        step(1'b0, 8'h01);
        lit("wrap_to_0", 8'h01, 3'd0, 1'b1);
        step(1'b0, 8'h00);
        lit("drop_idle", 8'h00, 3'd0, 1'b0);

        step(1'b1, 8'h00);
        step(1'b0, 8'hFF);
        lit("fair_start", 8'h01, 3'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            fair_req = 8'hFF & ~(8'd1 << k);
            step(1'b0, fair_req);
            nxt = (k + 1) % 8;
            lit("fair_order", 8'd1 << nxt, 3'(nxt), 1'b1);
        end

        step(1'b0, 8'h00);
        lit("idle_before_5", 8'h00, 3'd0, 1'b0);
        repeat (4) begin
            step(1'b0, 8'h20);
            lit("single_5", 8'h20, 3'd5, 1'b1);
        end
        step(1'b0, 8'h00);
        lit("idle_after_5", 8'h00, 3'd0, 1'b0);
        step(1'b0, 8'h21);
        lit("scan_from_6", 8'h01, 3'd0, 1'b1);

        step(1'b0, 8'h00);
        step(1'b0, 8'h08);
        lit("grant_3", 8'h08, 3'd3, 1'b1);
        step(1'b0, 8'h0A);
        lit("hold_3_new_req", 8'h08, 3'd3, 1'b1);
        step(1'b1, 8'h0A);
        lit("reset_mid", 8'h00, 3'd0, 1'b0);
        step(1'b0, 8'h0A);
        lit("after_reset", 8'h02, 3'd1, 1'b1);

        step(1'b1, 8'h00);
        for (int s = 0; s < 12; s++) begin
            step(1'b0, 8'h44);
`ifdef RR_ARBITER_TIMEOUT_EN
            exp_g = (((s / 4) % 2) == 0) ? 8'h04 : 8'h40;
`else
            exp_g = 8'h04;
`endif
            check("hold_limit", gnt, exp_g);
        end
        step(1'b0, 8'h00);
        lit("final_idle", 8'h00, 3'd0, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
